cacheline_adaptor: RTL and testbench



---
 rtl/cacheline_adaptor_pkg.sv | 18 +
 rtl/cacheline_adaptor.sv | 91 +++++++++
 tb/tb_cacheline_adaptor.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cacheline <-> burst adaptor.
package cacheline_adaptor_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one 256-bit line request into a four-beat 64-bit
// memory burst. Read beats are assembled into the line buffer. Write lines
// are sliced out of the same buffer. Every output comes from a register, or
// from a mux of registers, so no input reaches an output in the same cycle.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINE_W-1:0]  r_buf;
  logic [ADDR_W-1:0]  r_addr;
  logic               w_last_beat;

  // The final beat is the strobe that arrives while the counter sits on BEATS-1.
  assign w_last_beat = resp_i && (r_cnt == CNT_W'(BEATS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. A write wins over a read when both arrive in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (write_i)     w_state_nxt = WRITE;
        else if (read_i) w_state_nxt = READ;
      end
      READ:    if (w_last_beat) w_state_nxt = RESP;
      WRITE:   if (w_last_beat) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the request in IDLE, then advance the beat counter on each strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_buf  <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (write_i || read_i) begin
            r_addr <= {address_i[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            r_cnt  <= '0;
          end
          if (write_i) r_buf <= line_i;
        end
        READ: begin
          if (resp_i) begin
            r_buf[r_cnt*BEAT_W +: BEAT_W] <= burst_i;
            r_cnt                         <= r_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign read_o    = (r_state == READ);
  assign write_o   = (r_state == WRITE);
  assign resp_o    = (r_state == RESP);
  assign line_o    = r_buf;
  assign address_o = r_addr;
  assign burst_o   = r_buf[r_cnt*BEAT_W +: BEAT_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with a scoreboard of expected read lines.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [LINE_W-1:0] line_i;
  logic [ADDR_W-1:0] address_i;
  logic              read_i, write_i;
  logic [LINE_W-1:0] line_o;
  logic              resp_o;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o, write_o;
  logic              resp_i;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int resp_cnt = 0;
  logic [LINE_W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resp_o === 1'b1) resp_cnt <= resp_cnt + 1;

  localparam logic [LINE_W-1:0] RD_LINE0 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [LINE_W-1:0] WR_LINE0 = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
                                            64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
  localparam logic [LINE_W-1:0] RD_LINE1 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                            64'h5A5A_A5A5_5A5A_A5A5, 64'hDEAD_BEEF_CAFE_F00D};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One full line transaction. pat holds the resp_i value per burst cycle
  // (bit 0 first). Expected read data is queued at request time and popped
  // when resp_o shows up. Returns the cycle number of the resp_o cycle.
  task automatic txn(input string nm, input bit wr, input bit rd,
                     input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wline,
                     input logic [LINE_W-1:0] mline, input logic [7:0] pat,
                     input int plen, output int resp_cyc);
    int beat = 0;
    int r0;
    logic [LINE_W-1:0] exp_line;
    write_i = wr; read_i = rd; address_i = addr; line_i = wline;
    if (!wr) exp_q.push_back(mline);
    r0 = resp_cnt;
    tick;
    chk({nm, " address_o"}, LINE_W'(address_o), LINE_W'(addr & 32'hFFFF_FFE0));
    chk({nm, " write_o"}, LINE_W'(write_o), LINE_W'(wr));
    chk({nm, " read_o"}, LINE_W'(read_o), LINE_W'(!wr));
    for (int i = 0; i < plen; i++) begin
      resp_i  = pat[i];
      burst_i = pat[i] ? mline[beat*BEAT_W +: BEAT_W] : {$urandom, $urandom};
      if (wr) chk($sformatf("%s burst_o c%0d", nm, i), LINE_W'(burst_o), LINE_W'(wline[beat*BEAT_W +: BEAT_W]));
      chk($sformatf("%s resp_o early c%0d", nm, i), LINE_W'(resp_o), '0);
      if (pat[i]) beat++;
      tick;
    end
    resp_i = 1'b0;
    burst_i = '0;
    resp_cyc = cyc;
    chk({nm, " resp_o"}, LINE_W'(resp_o), LINE_W'(1));
    if (!wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s scoreboard: got empty queue expected entry", nm);
      end else begin
        exp_line = exp_q.pop_front();
        chk({nm, " line_o"}, line_o, exp_line);
      end
    end
    write_i = 1'b0; read_i = 1'b0;
    tick;
    chk({nm, " idle resp_o"}, LINE_W'(resp_o), '0);
    chk({nm, " idle rw_o"}, LINE_W'({read_o, write_o}), '0);
    chk({nm, " resp count"}, LINE_W'(resp_cnt - r0), LINE_W'(1));
  endtask

  task automatic test_reset;
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    line_i = '0; address_i = '0; burst_i = '0;
    tick; tick;
    chk("reset line_o", line_o, '0);
    chk("reset burst_o", LINE_W'(burst_o), '0);
    chk("reset address_o", LINE_W'(address_o), '0);
    chk("reset ctrl", LINE_W'({resp_o, read_o, write_o}), '0);
    rst = 1'b0;
    tick;
  endtask

  task automatic test_read_nogap;
    int rc;
    txn("read", 1'b0, 1'b1, 32'h0000_1234, '0, RD_LINE0, 8'b1111, 4, rc);
  endtask

  task automatic test_spurious_idle;
    int r0 = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      tick;
      chk($sformatf("spurious ctrl c%0d", i), LINE_W'({resp_o, read_o, write_o}), '0);
    end
    resp_i = 1'b0;
    tick;
    chk("spurious line_o", line_o, RD_LINE0);
    chk("spurious resp count", LINE_W'(resp_cnt - r0), '0);
  endtask

  task automatic test_write_stall;
    int rc;
    txn("write", 1'b1, 1'b0, 32'h8000_0040, WR_LINE0, '0, 8'b11101, 5, rc);
  endtask

  task automatic test_simultaneous;
    int rc;
    txn("both", 1'b1, 1'b1, 32'h0000_00FF, ~WR_LINE0, '0, 8'b1111, 4, rc);
  endtask

  task automatic test_reset_mid_burst;
    int r0 = resp_cnt;
    int rc;
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick;
    resp_i = 1'b1; burst_i = 64'h1111_1111_1111_1111; tick;
    burst_i = 64'h2222_2222_2222_2222; tick;
    resp_i = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst read_o", LINE_W'(read_o), '0);
    chk("midrst resp_o", LINE_W'(resp_o), '0);
    read_i = 1'b0;
    tick;
    chk("midrst stays idle", LINE_W'({resp_o, read_o, write_o}), '0);
    chk("midrst no resp", LINE_W'(resp_cnt - r0), '0);
    txn("post-rst read", 1'b0, 1'b1, 32'h0000_2010, '0, RD_LINE1, 8'b1111, 4, rc);
  endtask

  task automatic test_back_to_back;
    int rc1, rc2;
    txn("b2b read", 1'b0, 1'b1, 32'h0000_3000, '0, RD_LINE1, 8'b1111, 4, rc1);
    txn("b2b write", 1'b1, 1'b0, 32'h0000_3020, RD_LINE0, '0, 8'b1111, 4, rc2);
    chk("b2b spacing", LINE_W'(rc2 - rc1), LINE_W'(6));
  endtask

  initial begin
    test_reset;
    test_read_nogap;
    test_spurious_idle;
    test_write_stall;
    test_simultaneous;
    test_reset_mid_burst;
    test_back_to_back;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
